// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a valid/ready request side and a registered result.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, op; out_valid/out_ready with result, result_hi, carry, zero, div_by_zero.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcd_q, mcd_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cy_q, cy_d;
  logic             zf_q, zf_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             b_zero;
  logic             last;
  logic             fin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [W2-1:0]    mul_acc;
  logic [WIDTH:0]   rtop;
  logic [WIDTH:0]   dvs;
  logic             ge;
  logic [WIDTH-1:0] rnew;
  logic [W2-1:0]    div_acc;

  assign accept = in_valid && in_ready;
  assign b_zero = (b == '0);
  assign last   = (cnt_q == CNT_W'(1));
  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};

  // Shift-add: acc collects the product, mcd walks left, mpl walks right.
  assign mul_acc = mpl_q[0] ? acc_q + mcd_q : acc_q;

  // Restoring division: acc = {remainder, dividend/quotient}.
  // Trial is the remainder shifted left with the next dividend bit.
  assign rtop    = acc_q[W2-1:WIDTH-1];
  assign dvs     = {1'b0, mcd_q[WIDTH-1:0]};
  assign ge      = (rtop >= dvs);
  assign rnew    = ge ? WIDTH'(rtop - dvs) : rtop[WIDTH-1:0];
  assign div_acc = {rnew, acc_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == 3'b101)                 state_d = S_MUL;
          else if (op == 3'b110 && !b_zero) state_d = S_DIV;
          else                              state_d = S_DONE;
        end
      end
      S_MUL, S_DIV: if (last) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  always_comb begin
    acc_d = acc_q;
    mcd_d = mcd_q;
    mpl_d = mpl_q;
    cnt_d = cnt_q;
    res_d = res_q;
    hi_d  = hi_q;
    cy_d  = cy_q;
    zf_d  = zf_q;
    dz_d  = dz_q;
    ov_d  = ov_q;
    fin   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          fin  = 1'b1;
          hi_d = '0;
          cy_d = 1'b0;
          dz_d = 1'b0;
          unique case (op)
            3'b000: res_d = ~a;
            3'b001: res_d = a & b;
            3'b010: res_d = a | b;
            3'b111: res_d = a ^ b;
            3'b011: {cy_d, res_d} = sum;
            3'b100: {cy_d, res_d} = dif;
            3'b101: begin
              fin   = 1'b0;
              acc_d = '0;
              mcd_d = {{WIDTH{1'b0}}, a};
              mpl_d = b;
              cnt_d = CNT_W'(WIDTH);
            end
            3'b110: begin
              if (b_zero) begin
                res_d = '1;
                hi_d  = a;
                dz_d  = 1'b1;
              end else begin
                fin   = 1'b0;
                acc_d = {{WIDTH{1'b0}}, a};
                mcd_d = {{WIDTH{1'b0}}, b};
                cnt_d = CNT_W'(WIDTH);
              end
            end
            default: res_d = res_q;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        mcd_d = mcd_q << 1;
        mpl_d = mpl_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          fin   = 1'b1;
          res_d = mul_acc[WIDTH-1:0];
          hi_d  = mul_acc[W2-1:WIDTH];
          cy_d  = 1'b0;
          dz_d  = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          fin   = 1'b1;
          res_d = div_acc[WIDTH-1:0];
          hi_d  = div_acc[W2-1:WIDTH];
          cy_d  = 1'b0;
          dz_d  = 1'b0;
        end
      end
      S_DONE: if (out_ready) ov_d = 1'b0;
      default: ov_d = 1'b0;
    endcase
    if (fin) begin
      ov_d = 1'b1;
      zf_d = (res_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mcd_q <= '0;
      mpl_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      hi_q  <= '0;
      cy_q  <= 1'b0;
      zf_q  <= 1'b0;
      dz_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mcd_q <= mcd_d;
      mpl_q <= mpl_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      hi_q  <= hi_d;
      cy_q  <= cy_d;
      zf_q  <= zf_d;
      dz_q  <= dz_d;
      ov_q  <= ov_d;
    end
  end

  assign out_valid   = ov_q;
  assign result      = res_q;
  assign result_hi   = hi_q;
  assign carry       = cy_q;
  assign zero        = zf_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8 and WIDTH=32.
// Expected results are queued at accept and compared when out_valid rises.
`timescale 1ns/1ps
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, rdy8, ov8, or8, c8, z8, dz8;
  logic [7:0] a8, b8, r8, h8;
  logic [2:0] op8;

  logic        iv32, rdy32, ov32, or32, c32, z32, dz32;
  logic [31:0] a32, b32, r32, h32;
  logic [2:0]  op32;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .result_hi(h8),
    .carry(c8), .zero(z8), .div_by_zero(dz8)
  );

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(rdy32),
    .a(a32), .b(b32), .op(op32),
    .out_valid(ov32), .out_ready(or32),
    .result(r32), .result_hi(h32),
    .carry(c32), .zero(z32), .div_by_zero(dz32)
  );

  typedef struct {
    logic [63:0] r;
    logic [63:0] h;
    logic        c;
    logic        z;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic p8 = 1'b0;
  logic p32 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [2:0] o,
                                 logic [31:0] x, logic [31:0] y);
    logic [63:0] m, aa, bb, s;
    exp_t e;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, x} & m;
    bb = {32'd0, y} & m;
    s  = '0;
    e.r = '0; e.h = '0; e.c = 1'b0; e.dz = 1'b0;
    e.lat = 1; e.acc = 0;
    case (o)
      3'd0: e.r = ~aa & m;
      3'd1: e.r = aa & bb;
      3'd2: e.r = aa | bb;
      3'd7: e.r = aa ^ bb;
      3'd3: begin s = aa + bb; e.r = s & m; e.c = s[w]; end
      3'd4: begin e.r = (aa - bb) & m; e.c = (aa < bb); end
      3'd5: begin
        s = aa * bb; e.r = s & m; e.h = s >> w; e.lat = w + 1;
      end
      default: begin
        if (bb == 0) begin e.r = m; e.h = aa; e.dz = 1'b1; end
        else begin e.r = aa / bb; e.h = aa % bb; e.lat = w + 1; end
      end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic cmp(string p, exp_t e, logic [63:0] r, logic [63:0] h,
                     logic c, logic z, logic dz);
    chk({p, ".res"}, r, e.r);
    chk({p, ".res_hi"}, h, e.h);
    chk({p, ".carry"}, {63'd0, c}, {63'd0, e.c});
    chk({p, ".zero"}, {63'd0, z}, {63'd0, e.z});
    chk({p, ".dbz"}, {63'd0, dz}, {63'd0, e.dz});
    chk({p, ".lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
  endtask

  always @(negedge clk) begin
    if (rst) p8 = 1'b0;
    else begin
      if (ov8 && !p8) begin
        if (q8.size() == 0) chk("w8.spurious", 64'd1, 64'd0);
        else begin
          e8 = q8.pop_front();
          cmp("w8", e8, {56'd0, r8}, {56'd0, h8}, c8, z8, dz8);
        end
      end
      p8 = ov8;
    end
  end

  always @(negedge clk) begin
    if (rst) p32 = 1'b0;
    else begin
      if (ov32 && !p32) begin
        if (q32.size() == 0) chk("w32.spurious", 64'd1, 64'd0);
        else begin
          e32 = q32.pop_front();
          cmp("w32", e32, {32'd0, r32}, {32'd0, h32}, c32, z32, dz32);
        end
      end
      p32 = ov32;
    end
  end

  task automatic go(bit w32, logic [2:0] o, logic [31:0] x,
                    logic [31:0] y, int hold);
    exp_t  e;
    bit    seen;
    string t;
    t = w32 ? "w32" : "w8";
    e = model(w32 ? 32 : 8, o, x, y);
    @(negedge clk);
    if (w32) begin
      a32 = x; b32 = y; op32 = o; iv32 = 1'b1; or32 = (hold == 0);
    end else begin
      a8 = x[7:0]; b8 = y[7:0]; op8 = o; iv8 = 1'b1; or8 = (hold == 0);
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (w32) q32.push_back(e);
    else     q8.push_back(e);
    // Scramble inputs: the operation must use the latched values.
    if (w32) begin
      iv32 = 1'b0; a32 = ~x; b32 = x; op32 = ~o;
    end else begin
      iv8 = 1'b0; a8 = ~x[7:0]; b8 = x[7:0]; op8 = ~o;
    end
    seen = 1'b0;
    for (int i = 0; i < 48 && !seen; i++) begin
      @(negedge clk);
      chk({t, ".busy_rdy"}, {63'd0, w32 ? rdy32 : rdy8}, 64'd0);
      seen = w32 ? ov32 : ov8;
    end
    if (!seen) chk({t, ".timeout"}, 64'd0, 64'd1);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        if (w32) begin
          iv32 = 1'b1; op32 = 3'd3; a32 = 32'd1; b32 = 32'd1;
        end else begin
          iv8 = 1'b1; op8 = 3'd3; a8 = 8'd1; b8 = 8'd1;
        end
      end
      @(negedge clk);
      chk({t, ".hold_ov"}, {63'd0, w32 ? ov32 : ov8}, 64'd1);
      chk({t, ".hold_rdy"}, {63'd0, w32 ? rdy32 : rdy8}, 64'd0);
      chk({t, ".hold_res"}, w32 ? {32'd0, r32} : {56'd0, r8}, e.r);
    end
    if (w32) begin iv32 = 1'b0; or32 = 1'b1; end
    else     begin iv8 = 1'b0; or8 = 1'b1; end
    @(posedge clk);
    #1;
    chk({t, ".ret_rdy"}, {63'd0, w32 ? rdy32 : rdy8}, 64'd1);
    chk({t, ".ret_ov"}, {63'd0, w32 ? ov32 : ov8}, 64'd0);
    chk({t, ".held_res"}, w32 ? {32'd0, r32} : {56'd0, r8}, e.r);
  endtask

  task automatic chk_rst8(string p);
    chk({p, ".ov"}, {63'd0, ov8}, 64'd0);
    chk({p, ".rdy"}, {63'd0, rdy8}, 64'd1);
    chk({p, ".res"}, {56'd0, r8}, 64'd0);
    chk({p, ".hi"}, {56'd0, h8}, 64'd0);
    chk({p, ".flags"}, {61'd0, c8, z8, dz8}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
    #3;
    chk_rst8("rst8");
    chk("rst32.ov", {63'd0, ov32}, 64'd0);
    chk("rst32.rdy", {63'd0, rdy32}, 64'd1);
    chk("rst32.res", {32'd0, r32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    go(1'b0, 3'd3, 32'hFF, 32'h01, 0);
    go(1'b0, 3'd4, 32'h03, 32'h05, 0);
    go(1'b0, 3'd5, 32'hFF, 32'hFF, 0);
    go(1'b0, 3'd6, 32'd200, 32'd7, 0);
    go(1'b0, 3'd6, 32'd37, 32'd0, 0);

    // Abort a multiply with an asynchronous reset after three iterations.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h0F; op8 = 3'd5; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_rst8("midrst");
    @(negedge clk);
    rst = 1'b0;
    go(1'b0, 3'd3, 32'd5, 32'd3, 0);

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(0, 255);
      go(1'b0, o, x, y, 0);
    end

    go(1'b1, 3'd7, 32'hF0F0F0F0, 32'hFFFFFFFF, 5);
    go(1'b1, 3'd0, 32'h00000000, 32'h0, 0);
    go(1'b1, 3'd1, 32'h12345678, 32'h0, 0);
    go(1'b1, 3'd2, 32'hA0000000, 32'h0000000B, 0);
    go(1'b1, 3'd5, $urandom, $urandom, 0);
    go(1'b1, 3'd6, $urandom, $urandom_range(1, 1000), 0);
    go(1'b1, 3'd3, 32'hFFFFFFFF, 32'h00000001, 0);
    go(1'b1, 3'd4, 32'h00000010, 32'h00000011, 0);

    repeat (3) @(negedge clk);
    chk("sb8.empty", 64'(q8.size()), 64'd0);
    chk("sb32.empty", 64'(q32.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
